bcd_digit_shifter: RTL and testbench
====================================

# bcd_digit_shifter

Parametrised, multi-cycle BCD digit shifter that scales a packed BCD value by powers of ten.
- Shifts left (×10ⁿ) or right (÷10ⁿ, truncating) one digit per clock, with a START/DONE handshake.
- Reports digits lost off either end (OVF) and non-BCD input digits (ERR).
- Sits between the BCD entry/conversion logic and the display/arithmetic datapath. It replaces fixed single-cycle ×10/×100/×1000 selection with a generic N-digit shift.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits; data width is 4*DIGITS.
- AMT_W, $clog2(DIGITS+1), width of the shift-amount port.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- CLR_N, in, 1, reset, asynchronous assert, active-low.
- SCLR, in, 1, synchronous clear; same effect as reset; priority over START.
- START, in, 1, request an operation; accepted only when BUSY=0.
- D, in, 4*DIGITS, packed BCD operand; digit 0 is D[3:0].
- AMT, in, AMT_W, number of digit positions to shift.
- DIR, in, 1, 0 = left (toward MSD), 1 = right.
- FILL, in, 4, digit shifted into vacated positions.
- Q, out, 4*DIGITS, result register; holds its value between operations.
- BUSY, out, 1, high while shifting.
- DONE, out, 1, one-cycle pulse when Q holds the final result.
- OVF, out, 1, a nonzero digit was shifted out during the current/last operation.
- ERR, out, 1, D contained a digit greater than 9 at load.

## Operation
- States: IDLE, SHIFT, FIN.
- Reset (CLR_N=0 or SCLR=1):
  - Q=0, BUSY=0, DONE=0, OVF=0, ERR=0, state IDLE.
  - An operation in progress is abandoned immediately; no DONE pulse is produced.
- START accepted in IDLE or FIN:
  - Capture Q<=D, DIR and FILL into internal registers; cnt<=min(AMT, DIGITS).
  - Clear OVF; set ERR=1 if any digit of D is greater than 9, else ERR=0.
  - Next state is FIN if the clamped amount is 0, else SHIFT.
- SHIFT, one digit per cycle:
  - Left: Q<={Q[4*DIGITS-5:0], FILL}; the dropped digit is Q[4*DIGITS-1 -: 4].
  - Right: Q<={FILL, Q[4*DIGITS-1:4]}; the dropped digit is Q[3:0].
  - If the dropped digit is nonzero, OVF<=1 (sticky until the next accepted START).
  - cnt decrements each cycle; move to FIN after the shift that takes cnt from 1 to 0.
- FIN:
  - DONE=1 for exactly this cycle.
  - Goes to IDLE, or directly back into a new operation if START=1 in this cycle (back-to-back operations).
- START while in SHIFT is ignored, with no queueing.
- The captured DIR and FILL are used for the whole operation; input changes mid-operation have no effect.
- ERR is informational only: non-BCD digits are shifted like any other digit, and the operation still completes.
- AMT values above DIGITS are clamped to DIGITS: Q ends as all FILL digits, and OVF reflects every original digit.

## Timing
- START sampled at edge k:
  - Q=D visible after edge k.
  - DONE high in the cycle after edge k+n, where n = clamped AMT.
  - Latency is n+1 cycles; n=0 gives DONE one cycle after START.
- BUSY is high exactly for cycles in SHIFT (n cycles). BUSY is 0 in IDLE and FIN.
- Back-to-back throughput: one operation per n+1 cycles.
- OVF and ERR are registered and valid no later than the DONE cycle. They hold until the next accepted START or reset.
- Q updates only on START load and SHIFT cycles; otherwise it holds.

## Structure
- Shared package bcd_pkg holds:
  - BCD_DIGIT_W=4.
  - The state enum typedef (IDLE, SHIFT, FIN).
  - Function is_bcd_digit(logic [3:0]).
- No sub-module is required. The validity check is a generate loop over DIGITS calling is_bcd_digit.
- The FSM and datapath live in one always_ff, with the next-state logic in one always_comb.

## Test plan
- DIGITS=4; D=16'h0123, AMT=2, DIR=0, FILL=0, START pulse -> Q=16'h2300, OVF=1, ERR=0, BUSY high 2 cycles, DONE 3 cycles after START.
- D=16'h0042, AMT=2, DIR=0 -> Q=16'h4200, OVF=0.
- D=16'h1234, AMT=1, DIR=1, FILL=0 -> Q=16'h0123, OVF=1.
- D=16'h9999, AMT=0 -> Q=16'h9999 and DONE one cycle after START, BUSY never high. Then D=16'h1000, AMT=7, DIR=0, FILL=4'h0 issued in the FIN cycle -> accepted back-to-back, clamped to 4, Q=16'h0000, OVF=1.
- D=16'h12A4, AMT=1, DIR=0 -> ERR=1, operation completes with Q=16'h2A40, OVF=1.
- Start AMT=3, DIR=0; assert START again mid-SHIFT -> ignored. Then drop CLR_N mid-SHIFT -> Q=0, BUSY=0, OVF=0 immediately, no DONE pulse; a new START after release runs normally.

Source files
------------

// File: rtl/bcd_digit_shifter_pkg.sv
// Shared BCD definitions: digit width, shifter state encoding and a digit
// validity helper used by the BCD datapath blocks.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    // True when the nibble encodes a decimal digit 0..9.
    function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_shifter.sv
// Multi-cycle BCD digit shifter: scales a packed BCD value by 10^n (left) or
// divides by 10^n with truncation (right), one digit per clock, with a
// START/DONE handshake, sticky overflow on lost nonzero digits and a flag for
// non-BCD operand digits.
module bcd_digit_shifter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int AMT_W  = $clog2(DIGITS + 1)
) (
    input  logic                        clk,
    input  logic                        CLR_N,
    input  logic                        SCLR,
    input  logic                        START,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] D,
    input  logic [AMT_W-1:0]            AMT,
    input  logic                        DIR,
    input  logic [BCD_DIGIT_W-1:0]      FILL,
    output logic [BCD_DIGIT_W*DIGITS-1:0] Q,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        OVF,
    output logic                        ERR
);

    localparam int DW = BCD_DIGIT_W * DIGITS;
    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(DIGITS);

    state_t                 state;
    state_t                 state_nxt;
    logic [AMT_W-1:0]       cnt;
    logic                   dir_r;
    logic [BCD_DIGIT_W-1:0] fill_r;
    logic [AMT_W-1:0]       amt_clamped;
    logic                   load;
    logic [BCD_DIGIT_W-1:0] dropped;
    logic [DIGITS-1:0]      digit_ok;
    logic                   d_err;

    // Per-digit validity of the operand presented at load time.
    for (genvar i = 0; i < DIGITS; i++) begin : g_chk
        assign digit_ok[i] = is_bcd_digit(D[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end

    assign d_err       = ~&digit_ok;
    assign amt_clamped = (AMT > AMT_MAX) ? AMT_MAX : AMT;
    // A new request is taken whenever no shift is in flight (IDLE or FIN).
    assign load        = START && (state != SHIFT);
    assign dropped     = dir_r ? Q[BCD_DIGIT_W-1:0] : Q[DW-1 -: BCD_DIGIT_W];

    // Next-state selection for the IDLE/SHIFT/FIN sequencer.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, FIN: begin
                if (START) state_nxt = (amt_clamped == '0) ? FIN : SHIFT;
                else       state_nxt = IDLE;
            end
            SHIFT: begin
                if (cnt == AMT_W'(1)) state_nxt = FIN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, registered handshake outputs and the shift datapath.
    always_ff @(posedge clk or negedge CLR_N) begin
        if (!CLR_N) begin
            state  <= IDLE;
            Q      <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            OVF    <= 1'b0;
            ERR    <= 1'b0;
            cnt    <= '0;
            dir_r  <= 1'b0;
            fill_r <= '0;
        end else if (SCLR) begin
            state  <= IDLE;
            Q      <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            OVF    <= 1'b0;
            ERR    <= 1'b0;
            cnt    <= '0;
            dir_r  <= 1'b0;
            fill_r <= '0;
        end else begin
            state <= state_nxt;
            BUSY  <= (state_nxt == SHIFT);
            DONE  <= (state_nxt == FIN);
            if (load) begin
                Q      <= D;
                dir_r  <= DIR;
                fill_r <= FILL;
                cnt    <= amt_clamped;
                OVF    <= 1'b0;
                ERR    <= d_err;
            end else if (state == SHIFT) begin
                Q <= dir_r ? {fill_r, Q[DW-1:BCD_DIGIT_W]}
                           : {Q[DW-BCD_DIGIT_W-1:0], fill_r};
                if (dropped != '0) OVF <= 1'b1;
                cnt <= cnt - AMT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_digit_shifter.sv
// Self-checking bench for bcd_digit_shifter (DIGITS=4): directed scenarios
// plus randomized operations compared against a digit-queue reference model.
module tb_bcd_digit_shifter;

    localparam int DIGITS = 4;
    localparam int AMT_W  = 3;

    logic        clk = 1'b0;
    logic        CLR_N;
    logic        SCLR;
    logic        START;
    logic [15:0] D;
    logic [2:0]  AMT;
    logic        DIR;
    logic [3:0]  FILL;
    logic [15:0] Q;
    logic        BUSY;
    logic        DONE;
    logic        OVF;
    logic        ERR;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bcd_digit_shifter #(.DIGITS(DIGITS), .AMT_W(AMT_W)) dut (
        .clk  (clk),
        .CLR_N(CLR_N),
        .SCLR (SCLR),
        .START(START),
        .D    (D),
        .AMT  (AMT),
        .DIR  (DIR),
        .FILL (FILL),
        .Q    (Q),
        .BUSY (BUSY),
        .DONE (DONE),
        .OVF  (OVF),
        .ERR  (ERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the number is a list of decimal digits, MSD first.
    // Scaling by ten drops the MSD and appends FILL; dividing drops the LSD.
    function automatic void model(input logic [15:0] d, input int amt, input logic dir,
                                  input logic [3:0] fill, output logic [15:0] q,
                                  output logic ovf, output logic err);
        logic [3:0] dq[$];
        logic [3:0] gone;
        int n;
        err = 1'b0;
        ovf = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dq.push_back(d[4*i +: 4]);
            if (d[4*i +: 4] > 4'd9) err = 1'b1;
        end
        n = (amt > DIGITS) ? DIGITS : amt;
        for (int k = 0; k < n; k++) begin
            if (!dir) begin
                gone = dq.pop_front();
                dq.push_back(fill);
            end else begin
                gone = dq.pop_back();
                dq.push_front(fill);
            end
            if (gone != 4'd0) ovf = 1'b1;
        end
        q = {dq[0], dq[1], dq[2], dq[3]};
    endfunction

    // Issues one operation at the current falling edge and follows it to DONE.
    // Returns on the falling edge of the DONE cycle, so a following call is
    // issued back-to-back in FIN.
    task automatic run_op(input string tag, input logic [15:0] d, input logic [2:0] amt,
                          input logic dir, input logic [3:0] fill);
        logic [15:0] eq;
        logic        eovf;
        logic        eerr;
        int          n;
        int          t;
        int          busy_seen;
        model(d, int'(amt), dir, fill, eq, eovf, eerr);
        n = (int'(amt) > DIGITS) ? DIGITS : int'(amt);
        D = d; AMT = amt; DIR = dir; FILL = fill; START = 1'b1;
        @(posedge clk);
        @(negedge clk);
        START = 1'b0;
        D = 16'($urandom); AMT = 3'($urandom); DIR = 1'($urandom); FILL = 4'($urandom);
        check({tag, "_load"}, Q, d);
        t = 0;
        busy_seen = 0;
        while (!DONE && t < 20) begin
            if (BUSY) busy_seen++;
            @(negedge clk);
            t++;
        end
        check({tag, "_lat"}, t, n);
        check({tag, "_busy"}, busy_seen, n);
        check({tag, "_busy_fin"}, BUSY, 1'b0);
        check({tag, "_q"}, Q, eq);
        check({tag, "_ovf"}, OVF, eovf);
        check({tag, "_err"}, ERR, eerr);
    endtask

    initial begin
        int t;
        logic done_seen;
        logic [15:0] rd;
        CLR_N = 1'b0; SCLR = 1'b0; START = 1'b0;
        D = '0; AMT = '0; DIR = 1'b0; FILL = '0;
        repeat (2) @(negedge clk);
        check("rst_q", Q, 16'h0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_ovf", OVF, 1'b0);
        check("rst_err", ERR, 1'b0);
        CLR_N = 1'b1;
        @(negedge clk);

        run_op("tp1", 16'h0123, 3'd2, 1'b0, 4'h0);
        check("tp1_const_q", Q, 16'h2300);
        check("tp1_const_ovf", OVF, 1'b1);
        @(negedge clk);
        check("tp1_done_pulse", DONE, 1'b0);

        run_op("tp2", 16'h0042, 3'd2, 1'b0, 4'h0);
        check("tp2_const_q", Q, 16'h4200);
        check("tp2_const_ovf", OVF, 1'b0);
        @(negedge clk);

        run_op("tp3", 16'h1234, 3'd1, 1'b1, 4'h0);
        check("tp3_const_q", Q, 16'h0123);
        check("tp3_const_ovf", OVF, 1'b1);
        @(negedge clk);

        run_op("tp4", 16'h9999, 3'd0, 1'b0, 4'h0);
        check("tp4_const_q", Q, 16'h9999);
        run_op("tp5", 16'h1000, 3'd7, 1'b0, 4'h0);
        check("tp5_const_q", Q, 16'h0000);
        check("tp5_const_ovf", OVF, 1'b1);
        @(negedge clk);

        run_op("tp6", 16'h12A4, 3'd1, 1'b0, 4'h0);
        check("tp6_const_q", Q, 16'h2A40);
        check("tp6_const_err", ERR, 1'b1);
        @(negedge clk);

        // START during SHIFT must be ignored
        D = 16'h0123; AMT = 3'd3; DIR = 1'b0; FILL = 4'h5; START = 1'b1;
        @(posedge clk);
        @(negedge clk);
        START = 1'b0;
        t = 0;
        @(negedge clk);
        t++;
        START = 1'b1; D = 16'h9999; AMT = 3'd1; DIR = 1'b1; FILL = 4'h0;
        @(negedge clk);
        t++;
        START = 1'b0;
        while (!DONE && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("mid_lat", t, 3);
        check("mid_q", Q, 16'h3555);
        check("mid_ovf", OVF, 1'b1);
        @(negedge clk);

        // asynchronous reset mid-operation
        D = 16'h4321; AMT = 3'd3; DIR = 1'b0; FILL = 4'h0; START = 1'b1;
        @(posedge clk);
        @(negedge clk);
        START = 1'b0;
        @(negedge clk);
        CLR_N = 1'b0;
        #1;
        check("arst_q", Q, 16'h0);
        check("arst_busy", BUSY, 1'b0);
        check("arst_ovf", OVF, 1'b0);
        @(negedge clk);
        CLR_N = 1'b1;
        done_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            done_seen |= DONE;
        end
        check("arst_no_done", done_seen, 1'b0);
        run_op("post_arst", 16'h0567, 3'd1, 1'b0, 4'h8);
        @(negedge clk);

        // synchronous clear beats START
        D = 16'h12A4; AMT = 3'd4; DIR = 1'b1; FILL = 4'h0; START = 1'b1;
        @(posedge clk);
        @(negedge clk);
        START = 1'b0;
        @(negedge clk);
        SCLR = 1'b1; START = 1'b1; D = 16'h0777; AMT = 3'd0;
        @(negedge clk);
        SCLR = 1'b0; START = 1'b0;
        check("sclr_q", Q, 16'h0);
        check("sclr_busy", BUSY, 1'b0);
        check("sclr_err", ERR, 1'b0);
        check("sclr_done", DONE, 1'b0);
        done_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            done_seen |= DONE;
        end
        check("sclr_no_done", done_seen, 1'b0);
        run_op("post_sclr", 16'h8000, 3'd3, 1'b1, 4'h0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rd = 16'($urandom);
            end else begin
                for (int j = 0; j < 4; j++) rd[4*j +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check("rnd_idle_done", DONE, 1'b0);
            end
            run_op("rnd", rd, 3'($urandom_range(0, 7)), 1'($urandom),
                   4'($urandom_range(0, 9)));
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
